// File: rtl/myproject_div_21s_8s_14_seq_if.sv
// Operand/result handshake bundle for the sequential signed divider.
// The producer/consumer side uses master; the divider uses slave.
interface myproject_div_21s_8s_14_seq_if #(
    parameter int DIVIDEND_WIDTH = 21,
    parameter int DIVISOR_WIDTH  = 8,
    parameter int QUOTIENT_WIDTH = 14
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DIVIDEND_WIDTH-1:0] din0;
    logic [DIVISOR_WIDTH-1:0]  din1;
    logic                      out_valid;
    logic                      out_ready;
    logic [QUOTIENT_WIDTH-1:0] quot;
    logic [DIVISOR_WIDTH-1:0]  rem;
    logic                      ovf;
    logic                      dbz;

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, quot, rem, ovf, dbz
    );

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, quot, rem, ovf, dbz
    );
endinterface

// File: rtl/myproject_div_21s_8s_14_seq.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit
// per cycle, then sign fix-up with saturation to the quotient width.
module myproject_div_21s_8s_14_seq #(
    parameter int DIVIDEND_WIDTH = 21,
    parameter int DIVISOR_WIDTH  = 8,
    parameter int QUOTIENT_WIDTH = 14
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    myproject_div_21s_8s_14_seq_if.slave bus
);
    localparam int DW = DIVIDEND_WIDTH;
    localparam int VW = DIVISOR_WIDTH;
    localparam int QW = QUOTIENT_WIDTH;
    localparam int MW = DW + 1;
    localparam int CW = $clog2(DW);

    localparam logic [QW-1:0] QMAX_V   = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] QMIN_V   = {1'b1, {(QW-1){1'b0}}};
    localparam logic [MW-1:0] QPOS_LIM = MW'((2 ** (QW - 1)) - 1);
    localparam logic [MW-1:0] QNEG_LIM = MW'(2 ** (QW - 1));

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW-1:0] rmag_q, rmag_d;
    logic [MW-1:0] qmag_q, qmag_d;
    logic          sign0_q, sign0_d;
    logic          sign1_q, sign1_d;
    logic          zdiv_q, zdiv_d;
    logic [VW-1:0] low_q, low_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [QW-1:0] quot_q, quot_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          ovf_q, ovf_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   partial;
    logic [VW:0]   diff;
    logic          take;
    logic [MW-1:0] dvd_ext;
    logic [MW-1:0] qneg;
    logic [VW-1:0] rneg;
    logic          q_neg;
    logic          sat;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rmag_d      = rmag_q;
        qmag_d      = qmag_q;
        sign0_d     = sign0_q;
        sign1_d     = sign1_q;
        zdiv_d      = zdiv_q;
        low_d       = low_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;

        partial = {rmag_q, dvd_q[DW-1]};
        take    = partial >= {1'b0, dvs_q};
        diff    = partial - {1'b0, dvs_q};
        dvd_ext = {bus.din0[DW-1], bus.din0};
        qneg    = ~qmag_q + MW'(1);
        rneg    = ~rmag_q + VW'(1);
        q_neg   = sign0_q ^ sign1_q;
        // A negative quotient may reach one step further than a positive one.
        sat     = q_neg ? (qmag_q > QNEG_LIM) : (qmag_q > QPOS_LIM);

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    dvd_d      = bus.din0[DW-1] ? (~dvd_ext + MW'(1)) : dvd_ext;
                    dvs_d      = bus.din1[VW-1] ? (~bus.din1 + VW'(1)) : bus.din1;
                    sign0_d    = bus.din0[DW-1];
                    sign1_d    = bus.din1[VW-1];
                    zdiv_d     = (bus.din1 == '0);
                    low_d      = bus.din0[VW-1:0];
                    rmag_d     = '0;
                    qmag_d     = '0;
                    cnt_d      = CW'(DW - 1);
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                // Bit VW of partial is always clear when no subtraction happens.
                rmag_d = take ? diff[VW-1:0] : partial[VW-1:0];
                qmag_d = {qmag_q[MW-2:0], take};
                dvd_d  = {dvd_q[MW-2:0], 1'b0};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zdiv_q) begin
                    quot_d = sign0_q ? QMIN_V : QMAX_V;
                    rem_d  = low_q;
                    ovf_d  = 1'b0;
                    dbz_d  = 1'b1;
                end else begin
                    if (sat) begin
                        quot_d = q_neg ? QMIN_V : QMAX_V;
                    end else begin
                        quot_d = q_neg ? qneg[QW-1:0] : qmag_q[QW-1:0];
                    end
                    rem_d = sign0_q ? rneg : rmag_q;
                    ovf_d = sat;
                    dbz_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                out_valid_d = 1'b1;
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rmag_q      <= '0;
            qmag_q      <= '0;
            sign0_q     <= 1'b0;
            sign1_q     <= 1'b0;
            zdiv_q      <= 1'b0;
            low_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rmag_q      <= rmag_d;
            qmag_q      <= qmag_d;
            sign0_q     <= sign0_d;
            sign1_q     <= sign1_d;
            zdiv_q      <= zdiv_d;
            low_q       <= low_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quot      = quot_q;
    assign bus.rem       = rem_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbz       = dbz_q;
endmodule

// File: tb/tb_myproject_div_21s_8s_14_seq.sv
// Self-checking bench for the sequential signed divider: directed corner cases,
// back-pressure, mid-operation reset and a randomized back-to-back regression.
module tb_myproject_div_21s_8s_14_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    myproject_div_21s_8s_14_seq_if bus ();

    myproject_div_21s_8s_14_seq dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int acc_cnt = 0;
    int hs_cnt = 0;

    // Count accepted operands and consumed results as seen at the clock edge.
    always @(posedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) acc_cnt <= acc_cnt + 1;
        if (rst_n && bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;
    end

    // Reference: truncating signed division, saturated to 14 bits.
    function automatic void model(input int a, input int b, output int q, output int r,
                                  output bit ov, output bit dz);
        int qq;
        logic [7:0] lo;
        if (b == 0) begin
            dz = 1'b1;
            ov = 1'b0;
            q  = (a >= 0) ? 8191 : -8192;
            lo = a[7:0];
            r  = int'($signed(lo));
        end else begin
            dz = 1'b0;
            qq = a / b;
            r  = a % b;
            ov = (qq > 8191) || (qq < -8192);
            q  = (qq > 8191) ? 8191 : ((qq < -8192) ? -8192 : qq);
        end
    endfunction

    // Drives one operation starting at a negedge; returns the observed result and
    // the latency from the accept edge to out_valid (-1 on timeout).
    task automatic run_op(input int a, input int b, input int hold, output int q, output int r,
                          output bit ov, output bit dz, output int lat);
        int w;
        q = 0; r = 0; ov = 1'b0; dz = 1'b0; lat = -1;
        bus.in_valid = 1'b1;
        bus.din0 = a[20:0];
        bus.din1 = b[7:0];
        w = 0;
        while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus.out_valid) begin
            lat = -1;
            return;
        end
        q  = int'($signed(bus.quot));
        r  = int'($signed(bus.rem));
        ov = bus.ovf;
        dz = bus.dbz;
        repeat (hold) @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp += 6;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.quot !== 14'd0) begin n_fail++; $display("[TB] FAIL reset_quot: got %0d expected 0", bus.quot); end
        if (bus.rem !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_rem: got %0d expected 0", bus.rem); end
        if (bus.ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovf: got %b expected 0", bus.ovf); end
        if (bus.dbz !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dbz: got %b expected 0", bus.dbz); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_idle: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_directed();
        int va[15] = '{100, -100, 100, 1000000, -1048576, -1048576, -5, 0, 1000,
                       -1040384, 1040384, 1040257, -1048576, 1048575, -7};
        int vb[15] = '{7, 7, -7, 3, -1, 1, 0, 0, -128, 127, 127, 127, -128, -128, 3};
        int q, r, lat, eq, er;
        bit ov, dz, eov, edz;
        for (int i = 0; i < 15; i++) begin
            run_op(va[i], vb[i], 0, q, r, ov, dz, lat);
            model(va[i], vb[i], eq, er, eov, edz);
            n_cmp += 5;
            if (lat !== 23) begin n_fail++; $display("[TB] FAIL dir%0d_latency: got %0d expected 23", i, lat); end
            if (q !== eq) begin n_fail++; $display("[TB] FAIL dir%0d_quot (%0d/%0d): got %0d expected %0d", i, va[i], vb[i], q, eq); end
            if (r !== er) begin n_fail++; $display("[TB] FAIL dir%0d_rem (%0d/%0d): got %0d expected %0d", i, va[i], vb[i], r, er); end
            if (ov !== eov) begin n_fail++; $display("[TB] FAIL dir%0d_ovf: got %b expected %b", i, ov, eov); end
            if (dz !== edz) begin n_fail++; $display("[TB] FAIL dir%0d_dbz: got %b expected %b", i, dz, edz); end
        end
    endtask

    task automatic test_backpressure();
        int acc0, hs0, w, eq, er;
        logic [13:0] q0;
        logic [7:0] r0;
        logic ov0, dz0;
        bit eov, edz;
        acc0 = acc_cnt;
        hs0  = hs_cnt;
        bus.in_valid = 1'b1;
        bus.din0 = 21'd12345;
        bus.din1 = -8'sd37;
        @(posedge clk);
        @(negedge clk);
        bus.din0 = 21'd999;
        bus.din1 = 8'd5;
        repeat (5) @(negedge clk);
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (!bus.out_valid) begin n_fail++; $display("[TB] FAIL bp_out_valid_timeout: got 0 expected 1"); end
        q0 = bus.quot; r0 = bus.rem; ov0 = bus.ovf; dz0 = bus.dbz;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.out_valid, bus.in_ready, bus.quot, bus.rem, bus.ovf, bus.dbz} !==
                {1'b1, 1'b0, q0, r0, ov0, dz0}) begin
                n_fail++;
                $display("[TB] FAIL bp_hold_c%0d: got v=%b rdy=%b q=%0d r=%0d expected v=1 rdy=0 q=%0d r=%0d",
                         c, bus.out_valid, bus.in_ready, bus.quot, bus.rem, q0, r0);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        model(12345, -37, eq, er, eov, edz);
        n_cmp += 6;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_valid_drop: got %b expected 0", bus.out_valid); end
        if (acc_cnt - acc0 !== 1) begin n_fail++; $display("[TB] FAIL bp_accepts: got %0d expected 1", acc_cnt - acc0); end
        if (hs_cnt - hs0 !== 1) begin n_fail++; $display("[TB] FAIL bp_handshakes: got %0d expected 1", hs_cnt - hs0); end
        if (int'($signed(bus.quot)) !== eq) begin n_fail++; $display("[TB] FAIL bp_quot: got %0d expected %0d", $signed(bus.quot), eq); end
        if (int'($signed(bus.rem)) !== er) begin n_fail++; $display("[TB] FAIL bp_rem: got %0d expected %0d", $signed(bus.rem), er); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_reset_mid();
        int q, r, lat, eq, er, spurious;
        bit ov, dz, eov, edz;
        bus.in_valid = 1'b1;
        bus.din0 = 21'd50000;
        bus.din1 = 8'd9;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp += 2;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.out_valid) spurious++;
        end
        n_cmp++;
        if (spurious !== 0) begin n_fail++; $display("[TB] FAIL midrst_spurious_valid: got %0d cycles expected 0", spurious); end
        run_op(1000, -128, 0, q, r, ov, dz, lat);
        model(1000, -128, eq, er, eov, edz);
        n_cmp += 3;
        if (lat !== 23) begin n_fail++; $display("[TB] FAIL midrst_latency: got %0d expected 23", lat); end
        if (q !== eq) begin n_fail++; $display("[TB] FAIL midrst_quot: got %0d expected %0d", q, eq); end
        if (r !== er) begin n_fail++; $display("[TB] FAIL midrst_rem: got %0d expected %0d", r, er); end
    endtask

    task automatic test_random();
        localparam int N = 1200;
        int a, b, hold, q, r, lat, eq, er, acc0, hs0;
        bit ov, dz, eov, edz;
        acc0 = acc_cnt;
        hs0  = hs_cnt;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0: a = int'($urandom_range(0, 4000)) - 2000;
                1: begin
                    case ($urandom_range(0, 3))
                        0: a = -1048576;
                        1: a = 1048575;
                        2: a = 0;
                        default: a = -1;
                    endcase
                end
                default: a = int'($urandom_range(0, 2097151)) - 1048576;
            endcase
            b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
            hold = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
            run_op(a, b, hold, q, r, ov, dz, lat);
            model(a, b, eq, er, eov, edz);
            n_cmp += 5;
            if (lat !== 23) begin n_fail++; $display("[TB] FAIL rnd%0d_latency: got %0d expected 23", i, lat); end
            if (q !== eq) begin n_fail++; $display("[TB] FAIL rnd%0d_quot (%0d/%0d): got %0d expected %0d", i, a, b, q, eq); end
            if (r !== er) begin n_fail++; $display("[TB] FAIL rnd%0d_rem (%0d/%0d): got %0d expected %0d", i, a, b, r, er); end
            if (ov !== eov) begin n_fail++; $display("[TB] FAIL rnd%0d_ovf (%0d/%0d): got %b expected %b", i, a, b, ov, eov); end
            if (dz !== edz) begin n_fail++; $display("[TB] FAIL rnd%0d_dbz (%0d/%0d): got %b expected %b", i, a, b, dz, edz); end
        end
        n_cmp += 2;
        if (acc_cnt - acc0 !== N) begin n_fail++; $display("[TB] FAIL rnd_accepts: got %0d expected %0d", acc_cnt - acc0, N); end
        if (hs_cnt - hs0 !== N) begin n_fail++; $display("[TB] FAIL rnd_handshakes: got %0d expected %0d", hs_cnt - hs0, N); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.din0      = '0;
        bus.din1      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
